// File: rtl/fpu_driver.sv
// Host-side driver for a strobe/ack FPU: buffers operand pairs in a small FIFO and
// runs one pair at a time through the FPU, returning its result or a timeout error word.
module fpu_driver #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_z,
    output logic        rsp_err,
    output logic [31:0] output_a,
    output logic        output_a_stb,
    input  logic        output_a_ack,
    output logic [31:0] output_b,
    output logic        output_b_stb,
    input  logic        output_b_ack,
    input  logic [31:0] input_z,
    input  logic        input_z_stb,
    output logic        input_z_ack,
    output logic        busy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(TIMEOUT - 1);
    localparam logic [31:0]      ABORT_WORD = 32'hFFC0_0000;

    typedef enum logic [2:0] {IDLE, SEND_A, SEND_B, WAIT_Z, RESP} state_t;

    logic [63:0]      fifoMem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push, pop, fifoEmpty, fifoFull;
    logic [63:0]      headPair;

    state_t           state_q;
    logic [31:0]      opA_q, opB_q, rspZ_q;
    logic             aStb_q, bStb_q, zAck_q, rspValid_q, rspErr_q;
    logic [TMR_W-1:0] timer_q;

    // The FIFO only pops while the FSM is idle, so at most one pair is ever in flight.
    always_comb begin
        fifoEmpty = (count_q == '0);
        fifoFull  = (count_q == FULL_COUNT);
        push      = req_valid && !fifoFull;
        pop       = (state_q == IDLE) && !fifoEmpty;
        headPair  = fifoMem_q[rdPtr_q];
        wrPtr_d   = push ? wrPtr_q + PTR_W'(1) : wrPtr_q;
        rdPtr_d   = pop  ? rdPtr_q + PTR_W'(1) : rdPtr_q;
        count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifoMem_q[wrPtr_q] <= {req_a, req_b};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            opA_q      <= '0;
            opB_q      <= '0;
            aStb_q     <= 1'b0;
            bStb_q     <= 1'b0;
            zAck_q     <= 1'b0;
            rspValid_q <= 1'b0;
            rspZ_q     <= '0;
            rspErr_q   <= 1'b0;
            timer_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!fifoEmpty) begin
                        opA_q   <= headPair[63:32];
                        opB_q   <= headPair[31:0];
                        aStb_q  <= 1'b1;
                        state_q <= SEND_A;
                    end
                end
                SEND_A: begin
                    if (aStb_q && output_a_ack) begin
                        aStb_q  <= 1'b0;
                        bStb_q  <= 1'b1;
                        state_q <= SEND_B;
                    end
                end
                SEND_B: begin
                    if (bStb_q && output_b_ack) begin
                        bStb_q  <= 1'b0;
                        zAck_q  <= 1'b1;
                        timer_q <= '0;
                        state_q <= WAIT_Z;
                    end
                end
                // A real result always wins over an abort landing on the same edge.
                WAIT_Z: begin
                    if (input_z_stb && zAck_q) begin
                        rspZ_q     <= input_z;
                        rspErr_q   <= 1'b0;
                        zAck_q     <= 1'b0;
                        rspValid_q <= 1'b1;
                        state_q    <= RESP;
                    end else if (timer_q == TMR_LAST) begin
                        rspZ_q     <= ABORT_WORD;
                        rspErr_q   <= 1'b1;
                        zAck_q     <= 1'b0;
                        rspValid_q <= 1'b1;
                        state_q    <= RESP;
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
                RESP: begin
                    if (rspValid_q && rsp_ready) begin
                        rspValid_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready    = !fifoFull;
    assign output_a     = opA_q;
    assign output_b     = opB_q;
    assign output_a_stb = aStb_q;
    assign output_b_stb = bStb_q;
    assign input_z_ack  = zAck_q;
    assign rsp_valid    = rspValid_q;
    assign rsp_z        = rspZ_q;
    assign rsp_err      = rspErr_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_fpu_driver.sv
// Self-checking bench for fpu_driver: a behavioural FPU adder with programmable
// handshake delays, plus an in-order scoreboard of expected results.
module tb_fpu_driver;

    localparam int TB_DEPTH   = 4;
    localparam int TB_TIMEOUT = 1024;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_z;
    logic        rsp_err;
    logic [31:0] output_a;
    logic        output_a_stb;
    logic        output_a_ack;
    logic [31:0] output_b;
    logic        output_b_stb;
    logic        output_b_ack;
    logic [31:0] input_z;
    logic        input_z_stb;
    logic        input_z_ack;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    // Scoreboard of results the host should see, in push order.
    logic [31:0] expQ [$];
    bit          sawFull;

    // FPU model configuration and observation state.
    int          ackDelayA = 0;
    int          ackDelayB = 0;
    int          zDelay    = 0;
    bit          zNever    = 0;
    int          aWait, bWait, zCount;
    bit          zPending;
    logic [31:0] zResult, capA, aFirst, bFirst;
    bit          aHeld, bHeld, aUnstable, bUnstable;
    int          aXfers, bXfers, bStbCycles;

    fpu_driver #(
        .DEPTH  (TB_DEPTH),
        .TIMEOUT(TB_TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_z       (rsp_z),
        .rsp_err     (rsp_err),
        .output_a    (output_a),
        .output_a_stb(output_a_stb),
        .output_a_ack(output_a_ack),
        .output_b    (output_b),
        .output_b_stb(output_b_stb),
        .output_b_ack(output_b_ack),
        .input_z     (input_z),
        .input_z_stb (input_z_stb),
        .input_z_ack (input_z_ack),
        .busy        (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single-precision <-> real conversion for normal numbers, used by the adder model.
    function automatic real toReal(input logic [31:0] x);
        logic [63:0] d;
        logic [10:0] e11;
        if (x[30:23] == 8'd0) begin
            d = {x[31], 63'd0};
        end else begin
            e11 = {3'b000, x[30:23]} + 11'd896;
            d   = {x[31], e11, x[22:0], 29'd0};
        end
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] toSingle(input real r);
        logic [63:0] d;
        int          e;
        logic [7:0]  e8;
        d  = $realtobits(r);
        e  = int'(d[62:52]) - 896;
        if (d[62:52] == 11'd0 || e <= 0) return {d[63], 31'd0};
        if (e >= 255) return {d[63], 8'hFF, 23'd0};
        e8 = e[7:0];
        return {d[63], e8, d[51:29]};
    endfunction

    function automatic logic [31:0] fpuAdd(input logic [31:0] a, input logic [31:0] b);
        return toSingle(toReal(a) + toReal(b));
    endfunction

    function automatic logic [31:0] randFloat();
        logic       s;
        logic [7:0] e;
        logic [22:0] m;
        s = 1'($urandom_range(0, 1));
        e = 8'($urandom_range(120, 134));
        m = 23'($urandom);
        return {s, e, m};
    endfunction

    // Behavioural FPU: acks operands after programmable delays, then presents
    // the sum zDelay cycles later. Everything is driven on the falling edge.
    initial begin
        output_a_ack = 1'b0;
        output_b_ack = 1'b0;
        input_z_stb  = 1'b0;
        input_z      = '0;
        zPending     = 0;
        aWait = 0; bWait = 0; zCount = 0;
        aHeld = 0; bHeld = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                output_a_ack = 1'b0;
                output_b_ack = 1'b0;
                input_z_stb  = 1'b0;
                zPending = 0;
                aWait = 0; bWait = 0;
                aHeld = 0; bHeld = 0;
            end else begin
                if (zPending && !zNever) begin
                    if (zCount > 0) begin
                        zCount--;
                        input_z_stb = 1'b0;
                    end else begin
                        input_z_stb = 1'b1;
                        input_z     = zResult;
                        if (input_z_ack) zPending = 0;
                    end
                end else begin
                    input_z_stb = 1'b0;
                end

                if (output_a_stb) begin
                    if (!aHeld) begin
                        aHeld  = 1;
                        aFirst = output_a;
                    end else if (output_a !== aFirst) begin
                        aUnstable = 1;
                    end
                    if (aWait >= ackDelayA) begin
                        output_a_ack = 1'b1;
                        capA = output_a;
                        aXfers++;
                        aHeld = 0;
                        aWait = 0;
                    end else begin
                        output_a_ack = 1'b0;
                        aWait++;
                    end
                end else begin
                    output_a_ack = 1'b0;
                    aHeld = 0;
                    aWait = 0;
                end

                if (output_b_stb) begin
                    bStbCycles++;
                    if (!bHeld) begin
                        bHeld  = 1;
                        bFirst = output_b;
                    end else if (output_b !== bFirst) begin
                        bUnstable = 1;
                    end
                    if (bWait >= ackDelayB) begin
                        output_b_ack = 1'b1;
                        bXfers++;
                        zResult  = fpuAdd(capA, output_b);
                        zCount   = zDelay;
                        zPending = 1;
                        bHeld = 0;
                        bWait = 0;
                    end else begin
                        output_b_ack = 1'b0;
                        bWait++;
                    end
                end else begin
                    output_b_ack = 1'b0;
                    bHeld = 0;
                    bWait = 0;
                end
            end
        end
    end

    // Offers one pair to the host port (entered on a falling edge); ok=0 if never accepted.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, output bit ok);
        ok        = 0;
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        for (int n = 0; n < 3000; n++) begin
            if (req_ready) begin
                ok = 1;
                expQ.push_back(fpuAdd(a, b));
                break;
            end
            sawFull = 1;
            @(negedge clk);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Takes one response with rsp_ready held high; ok=0 if none appeared in time.
    task automatic collectResponse(output logic [31:0] z, output logic e, output bit ok,
                                   input int limit);
        ok = 0;
        z  = '0;
        e  = 1'b0;
        rsp_ready = 1'b1;
        for (int n = 0; n < limit; n++) begin
            if (rsp_valid) begin
                z  = rsp_z;
                e  = rsp_err;
                ok = 1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        rsp_ready = 1'b0;
    endtask

    task automatic pulseReset();
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
    endtask

    // Everything idle, zeroed and ready while reset is held, and nothing starts after release.
    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({output_a_stb, output_b_stb, input_z_ack, rsp_valid, rsp_err, busy} !== 6'b0) begin
            failures++;
            $display("[TB] FAIL reset_flags got=%b exp=000000",
                     {output_a_stb, output_b_stb, input_z_ack, rsp_valid, rsp_err, busy});
        end
        checks++;
        if ({output_a, output_b, rsp_z} !== 96'd0) begin
            failures++;
            $display("[TB] FAIL reset_data got a=%h b=%h z=%h exp all 0", output_a, output_b, rsp_z);
        end
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_ready got=%b exp=1", req_ready);
        end
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, req_ready} !== 2'b01) begin
            failures++;
            $display("[TB] FAIL post_reset_idle got busy=%b ready=%b exp busy=0 ready=1", busy, req_ready);
        end
    endtask

    // 1.0 + 2.0 with a 2-cycle adder: one transfer per operand, result 3.0, minimum latency.
    task automatic test_single_add();
        logic [31:0] z, exp;
        logic        e;
        bit          ok;
        int          lat;
        ackDelayA = 0; ackDelayB = 0; zDelay = 2;
        aXfers = 0; bXfers = 0; aUnstable = 0; bUnstable = 0;
        applyStimulus(32'h3F80_0000, 32'h4000_0000, ok);
        for (int n = 0; n < 20 && !busy; n++) @(negedge clk);
        lat = 0;
        while (!rsp_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat !== 3 + ackDelayA + ackDelayB + zDelay) begin
            failures++;
            $display("[TB] FAIL single_latency got=%0d exp=%0d", lat, 3 + zDelay);
        end
        collectResponse(z, e, ok, 50);
        exp = expQ.pop_front();
        checks++;
        if (!ok || z !== 32'h4040_0000 || exp !== 32'h4040_0000) begin
            failures++;
            $display("[TB] FAIL single_result got=%h model=%h exp=40400000 seen=%0b", z, exp, ok);
        end
        checks++;
        if (e !== 1'b0) begin
            failures++;
            $display("[TB] FAIL single_err got=%b exp=0", e);
        end
        checks++;
        if (aXfers !== 1 || bXfers !== 1 || aUnstable || bUnstable) begin
            failures++;
            $display("[TB] FAIL single_xfers got a=%0d b=%0d unstable=%0b%0b exp a=1 b=1 unstable=00",
                     aXfers, bXfers, aUnstable, bUnstable);
        end
    endtask

    // Five pairs with the host stalled: the FIFO fills, a sixth is refused, then all drain in order.
    task automatic test_back_to_back();
        logic [31:0] z, exp;
        logic        e;
        bit          ok;
        int          accepted;
        ackDelayA = 0; ackDelayB = 0; zDelay = 1;
        rsp_ready = 1'b0;
        accepted  = 0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(randFloat(), randFloat(), ok);
            if (ok) accepted++;
        end
        checks++;
        if (accepted !== 5 || req_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_fill got accepted=%0d ready=%b exp accepted=5 ready=0", accepted, req_ready);
        end
        req_valid = 1'b1;
        req_a = randFloat();
        req_b = randFloat();
        repeat (5) @(negedge clk);
        checks++;
        if (req_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_hold got ready=%b exp=0", req_ready);
        end
        req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            collectResponse(z, e, ok, 200);
            exp = (expQ.size() > 0) ? expQ.pop_front() : 32'hDEAD_BEEF;
            checks++;
            if (!ok || z !== exp || e !== 1'b0) begin
                failures++;
                $display("[TB] FAIL b2b_result[%0d] got z=%h err=%b seen=%0b exp z=%h err=0", i, z, e, ok, exp);
            end
        end
        repeat (10) @(negedge clk);
        checks++;
        if ({busy, rsp_valid} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL b2b_drained got busy=%b rsp_valid=%b exp 0 0", busy, rsp_valid);
        end
    endtask

    // An FPU that never answers: abort after exactly TIMEOUT cycles of waiting.
    task automatic test_timeout();
        logic [31:0] z;
        logic        e;
        bit          ok;
        int          n;
        zNever = 1; zDelay = 0;
        applyStimulus(randFloat(), randFloat(), ok);
        void'(expQ.pop_front());
        for (int k = 0; k < 50 && !input_z_ack; k++) @(negedge clk);
        n = 0;
        while (input_z_ack && n < TB_TIMEOUT + 50) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n !== TB_TIMEOUT) begin
            failures++;
            $display("[TB] FAIL timeout_cycles got=%0d exp=%0d", n, TB_TIMEOUT);
        end
        collectResponse(z, e, ok, 10);
        checks++;
        if (!ok || z !== 32'hFFC0_0000 || e !== 1'b1) begin
            failures++;
            $display("[TB] FAIL timeout_result got z=%h err=%b seen=%0b exp z=ffc00000 err=1", z, e, ok);
        end
        pulseReset();
        zNever = 0;
    endtask

    // Operand B acked 10 cycles late: strobe held with stable data, normal result, no abort.
    task automatic test_slow_b();
        logic [31:0] z, exp;
        logic        e;
        bit          ok;
        ackDelayA = 0; ackDelayB = 10; zDelay = 1;
        bStbCycles = 0; bUnstable = 0;
        applyStimulus(randFloat(), randFloat(), ok);
        collectResponse(z, e, ok, 200);
        exp = expQ.pop_front();
        checks++;
        if (!ok || z !== exp || e !== 1'b0) begin
            failures++;
            $display("[TB] FAIL slowb_result got z=%h err=%b seen=%0b exp z=%h err=0", z, e, ok, exp);
        end
        checks++;
        if (bStbCycles !== 11 || bUnstable) begin
            failures++;
            $display("[TB] FAIL slowb_strobe got cycles=%0d unstable=%0b exp cycles=11 unstable=0",
                     bStbCycles, bUnstable);
        end
        ackDelayB = 0;
    endtask

    // Reset while waiting for Z with pairs still queued: outputs drop at once, nothing restarts.
    task automatic test_reset_midflight();
        bit ok;
        bit activity;
        zNever = 1;
        for (int i = 0; i < 3; i++) applyStimulus(randFloat(), randFloat(), ok);
        for (int k = 0; k < 50 && !input_z_ack; k++) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({output_a_stb, output_b_stb, input_z_ack, rsp_valid, rsp_err, busy} !== 6'b0) begin
            failures++;
            $display("[TB] FAIL midreset_flags got=%b exp=000000",
                     {output_a_stb, output_b_stb, input_z_ack, rsp_valid, rsp_err, busy});
        end
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL midreset_ready got=%b exp=1", req_ready);
        end
        @(negedge clk);
        #2 rst = 1'b0;
        expQ.delete();
        zNever   = 0;
        activity = 0;
        repeat (6) begin
            @(negedge clk);
            if (busy || output_a_stb || output_b_stb || input_z_ack || rsp_valid) activity = 1;
        end
        checks++;
        if (activity !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midreset_quiet got activity=%b exp=0", activity);
        end
    endtask

    // Continuous random traffic against a slow, random host: FIFO runs full and wraps many times.
    task automatic test_wrap();
        localparam int N = 16;
        ackDelayA = 1; ackDelayB = 0; zDelay = $urandom_range(0, 3);
        sawFull   = 0;
        fork
            begin
                bit ok;
                for (int i = 0; i < N; i++) begin
                    applyStimulus(randFloat(), randFloat(), ok);
                    checks++;
                    if (!ok) begin
                        failures++;
                        $display("[TB] FAIL wrap_push[%0d] got accepted=0 exp=1", i);
                    end
                end
            end
            begin
                logic [31:0] z, exp;
                logic        e;
                bit          got;
                int          n;
                repeat (20) @(negedge clk);
                for (int i = 0; i < N; i++) begin
                    got = 0;
                    n   = 0;
                    z   = '0;
                    e   = 1'b0;
                    while (!got && n < 3000) begin
                        rsp_ready = ($urandom_range(0, 3) != 0);
                        if (rsp_valid && rsp_ready) begin
                            got = 1;
                            z   = rsp_z;
                            e   = rsp_err;
                        end
                        @(negedge clk);
                        n++;
                    end
                    exp = (expQ.size() > 0) ? expQ.pop_front() : 32'hDEAD_BEEF;
                    checks++;
                    if (!got || z !== exp || e !== 1'b0) begin
                        failures++;
                        $display("[TB] FAIL wrap_result[%0d] got z=%h err=%b seen=%0b exp z=%h err=0",
                                 i, z, e, got, exp);
                    end
                end
                rsp_ready = 1'b0;
            end
        join
        checks++;
        if (sawFull !== 1'b1 || expQ.size() !== 0) begin
            failures++;
            $display("[TB] FAIL wrap_full got sawFull=%b leftover=%0d exp sawFull=1 leftover=0",
                     sawFull, expQ.size());
        end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        test_reset();
        test_single_add();
        test_back_to_back();
        test_timeout();
        test_slow_b();
        test_reset_midflight();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog got=running exp=finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
